// File: rtl/issue_queue_pkg.sv
// Shared types for the schedule-stage issue queues.
// res_st_cell_t is one reservation-station entry handed to an execution unit.
package issue_queue_pkg;

    typedef struct packed {
        logic [5:0] rob_tag;
        logic [4:0] dst_reg;
        logic [4:0] src_reg;
        logic [7:0] payload;
    } res_st_cell_t;

endpackage

// File: rtl/issue_queue.sv
// First-word-fall-through issue queue between the schedule stage and one execution unit.
// Circular buffer with a separate occupancy counter, flush support and a sticky overflow flag.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AF_SLACK = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  res_st_cell_t              wr_data,
    output logic                      full,
    output logic                      almost_full,
    output logic                      rd_valid,
    output res_st_cell_t              rd_data,
    input  logic                      rd_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    res_st_cell_t mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic [31:0]   free_slots;
    logic          push;
    logic          pop;

    // Handshake: the head is consumed at a rising edge where rd_valid && rd_ready;
    // rd_valid/rd_data hold steady while stalled, and a push into a full queue is
    // only accepted when the head leaves in the same cycle.
    assign rd_valid    = (cnt_q != '0);
    assign full        = (cnt_q == CW'(DEPTH));
    assign free_slots  = 32'(DEPTH) - 32'(cnt_q);
    assign almost_full = (free_slots <= 32'(AF_SLACK));
    assign count       = cnt_q;
    assign overflow    = ovf_q;
    assign rd_data     = rd_valid ? mem[rp] : '0;

    assign pop  = rd_valid && rd_ready;
    assign push = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (wr_en && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage is never cleared; stale slots are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wp] <= wr_data;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Randomized scoreboard bench for issue_queue with an abstract queue model.
// The driver updates the expected-content queue; a monitor checks status and popped heads.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH    = 8;
  localparam int AF_SLACK = 2;
  localparam int W        = $bits(res_st_cell_t);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic                   wr_en = 1'b0;
  logic [W-1:0]           wr_data = '0;
  logic                   rd_ready = 1'b0;
  logic                   full;
  logic                   almost_full;
  logic                   rd_valid;
  logic [W-1:0]           rd_data;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  logic [W-1:0] exp_q[$];
  logic         m_ovf = 1'b0;
  logic         checking = 1'b0;
  int           n_checks = 0;
  int           n_bad = 0;

  issue_queue #(.DEPTH(DEPTH), .AF_SLACK(AF_SLACK)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .count       (count),
    .overflow    (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver: one cycle of stimulus, then the reference model absorbs its effect
  task automatic cyc(input logic we, input logic [W-1:0] d, input logic rr,
                     input logic fl, input logic rs);
    int sz;
    @(negedge clk);
    wr_en = we;
    wr_data = d;
    rd_ready = rr;
    flush = fl;
    rst = rs;
    sz = exp_q.size();
    #3;
    if (rs) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      exp_q.delete();
    end else if (we) begin
      if (sz < DEPTH || (sz > 0 && rr)) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic push_n(input int n, input logic rr, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) cyc(1'b1, base + W'(i), rr, 1'b0, 1'b0);
  endtask

  task automatic idle_n(input int n, input logic rr);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, rr, 1'b0, 1'b0);
  endtask

  // monitor: status against the model, head data against the scoreboard
  always @(negedge clk) begin
    #2;
    if (checking) begin
      chk("count", count, exp_q.size());
      chk("rd_valid", rd_valid, exp_q.size() != 0);
      chk("full", full, exp_q.size() == DEPTH);
      chk("almost_full", almost_full, (DEPTH - exp_q.size()) <= AF_SLACK);
      chk("overflow", overflow, m_ovf);
      if (!rd_valid) begin
        chk("rd_data_idle", rd_data, 0);
      end else if (exp_q.size() != 0) begin
        chk("rd_data_head", rd_data, exp_q[0]);
        if (rd_ready && !flush && !rst) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checking = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // fill in order, stall, overflow
    cyc(1'b1, W'(8'hA1), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'(8'hA2), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'(8'hA3), 1'b0, 1'b0, 1'b0);
    push_n(5, 1'b0, W'(8'hC0));
    cyc(1'b1, W'(8'hFF), 1'b0, 1'b0, 1'b0);
    idle_n(2, 1'b0);

    // push while full with simultaneous pop, then drain across the wrap
    cyc(1'b1, W'(8'hB0), 1'b1, 1'b0, 1'b0);
    idle_n(10, 1'b1);

    // streaming at one entry per cycle
    push_n(20, 1'b1, W'(8'h40));
    idle_n(3, 1'b1);

    // flush with concurrent push and pop
    push_n(5, 1'b0, W'(8'h60));
    cyc(1'b1, W'(8'h77), 1'b1, 1'b1, 1'b0);
    cyc(1'b1, W'(8'h5A), 1'b0, 1'b0, 1'b0);
    idle_n(3, 1'b1);

    // reset mid-stream at count 4
    push_n(4, 1'b0, W'(8'h80));
    cyc(1'b1, W'(8'h90), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, W'(8'h91), 1'b1, 1'b0, 1'b1);
    idle_n(2, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 65, W'($urandom), $urandom_range(0, 99) < 45,
          $urandom_range(0, 59) == 0, $urandom_range(0, 249) == 0);
    end
    idle_n(DEPTH + 2, 1'b1);

    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
